// File: rtl/mc_mem_responder.sv
// mc_mem_responder: word-addressed memory responder with programmable wait states and error flagging
module mc_mem_responder #(
  parameter int DEPTH_LOG2  = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] tom,
  output logic [31:0] fromm,
  output logic        ready,
  output logic        err,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic we_q, we_d, err_q, err_d;
  logic [31:0] adr_q, adr_d, tom_q, tom_d, fromm_q, fromm_d;
  logic [31:0] mem_q [2**DEPTH_LOG2];
  logic go_resp, cur_we, bad, wr_en;
  logic [31:0] cur_adr, cur_tom;
  logic [DEPTH_LOG2-1:0] idx;
  // current access: live inputs in IDLE (zero-wait accept), latched copies otherwise
  always_comb begin
    cur_we  = state_q == IDLE ? we  : we_q;
    cur_adr = state_q == IDLE ? adr : adr_q;
    cur_tom = state_q == IDLE ? tom : tom_q;
    idx     = cur_adr[DEPTH_LOG2+1:2];
    bad     = (|cur_adr[1:0]) || (|(cur_adr >> (DEPTH_LOG2 + 2)));
    go_resp = (state_q == IDLE && req && WAIT_CYCLES == 0) || (state_q == WAIT && cnt_q == 4'd1);
    wr_en   = go_resp && cur_we && !bad;
    fromm_d = (go_resp && !cur_we && !bad) ? mem_q[idx] : fromm_q;
    err_d   = go_resp && bad;
  end
  // next-state logic: accept in IDLE, count down in WAIT, single ready cycle in RESP
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    adr_d   = adr_q;
    tom_d   = tom_q;
    unique case (state_q)
      IDLE: if (req) begin
        we_d    = we;
        adr_d   = adr;
        tom_d   = tom;
        cnt_d   = 4'(WAIT_CYCLES);
        state_d = WAIT_CYCLES == 0 ? RESP : WAIT;
      end
      WAIT: begin
        cnt_d   = cnt_q - 4'd1;
        state_d = cnt_q == 4'd1 ? RESP : WAIT;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // control and data registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      tom_q   <= '0;
      fromm_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      tom_q   <= tom_d;
      fromm_q <= fromm_d;
      err_q   <= err_d;
    end
  end
  // memory array: cleared on reset, written on the edge entering RESP
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 2**DEPTH_LOG2; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[idx] <= cur_tom;
    end
  end
  assign fromm = fromm_q;
  assign ready = state_q == RESP;
  assign err   = err_q;
  assign busy  = state_q != IDLE;
endmodule

// File: tb/tb_mc_mem_responder.sv
// tb_mc_mem_responder: directed checks of the memory responder at wait settings 2, 0 and 15
module tb_mc_mem_responder;
  logic clock = 1'b0, reset = 1'b1;
  logic req2 = 1'b0, req0 = 1'b0, req15 = 1'b0, we = 1'b0;
  logic [31:0] adr = '0, tom = '0;
  logic [31:0] fromm2, fromm0, fromm15;
  logic ready2, ready0, ready15, err2, err0, err15, busy2, busy0, busy15;
  int checks = 0, errors = 0;
  int lat, bc, f0, s0, f15, s15;

  always #5 clock = ~clock;

  mc_mem_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(2)) u2 (
    .clock(clock), .reset(reset), .req(req2), .we(we), .adr(adr), .tom(tom),
    .fromm(fromm2), .ready(ready2), .err(err2), .busy(busy2));
  mc_mem_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(0)) u0 (
    .clock(clock), .reset(reset), .req(req0), .we(we), .adr(adr), .tom(tom),
    .fromm(fromm0), .ready(ready0), .err(err0), .busy(busy0));
  mc_mem_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(15)) u15 (
    .clock(clock), .reset(reset), .req(req15), .we(we), .adr(adr), .tom(tom),
    .fromm(fromm15), .ready(ready15), .err(err15), .busy(busy15));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // issue one request to u2; optionally scramble the inputs while it waits
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input bit scr, output int n, output int b);
    for (int i = 0; i < 40 && busy2; i++) @(negedge clock);
    req2 = 1'b1; we = w; adr = a; tom = d;
    @(negedge clock);
    req2 = 1'b0;
    n = 1;
    b = int'(busy2);
    if (scr) begin we = ~w; adr = 32'h20; tom = 32'hdeadbeef; end
    while (!ready2 && n < 40) begin
      @(negedge clock);
      n++;
      b += int'(busy2);
    end
  endtask

  initial begin
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk("rst_ready", {31'b0, ready2}, 0);
    chk("rst_err", {31'b0, err2}, 0);
    chk("rst_busy", {31'b0, busy2}, 0);
    chk("rst_fromm", fromm2, 0);
    do_req(1'b0, 32'h10, 0, 0, lat, bc);
    chk("rd10_lat", lat, 3);
    chk("rd10_busy", bc, 3);
    chk("rd10_data", fromm2, 0);
    chk("rd10_err", {31'b0, err2}, 0);
    do_req(1'b1, 32'h08, 32'h12345678, 0, lat, bc);
    chk("wr08_lat", lat, 3);
    chk("wr08_err", {31'b0, err2}, 0);
    chk("wr08_fromm", fromm2, 0);
    do_req(1'b0, 32'h08, 0, 0, lat, bc);
    chk("rd08_data", fromm2, 32'h12345678);
    chk("rd08_err", {31'b0, err2}, 0);
    do_req(1'b0, 32'h06, 0, 0, lat, bc);
    chk("mis_lat", lat, 3);
    chk("mis_err", {31'b0, err2}, 1);
    chk("mis_fromm", fromm2, 32'h12345678);
    @(negedge clock);
    chk("mis_ready_drop", {31'b0, ready2}, 0);
    chk("mis_err_drop", {31'b0, err2}, 0);
    do_req(1'b1, 32'h100, 32'h55aa55aa, 0, lat, bc);
    chk("oor_err", {31'b0, err2}, 1);
    chk("oor_lat", lat, 3);
    do_req(1'b0, 32'h000, 0, 0, lat, bc);
    chk("rd00_data", fromm2, 0);
    chk("rd00_err", {31'b0, err2}, 0);
    do_req(1'b0, 32'h08, 0, 1, lat, bc);
    chk("scr_data", fromm2, 32'h12345678);
    chk("scr_err", {31'b0, err2}, 0);
    do_req(1'b0, 32'h20, 0, 0, lat, bc);
    chk("scr_no_wr20", fromm2, 0);
    do_req(1'b0, 32'h08, 0, 0, lat, bc);
    chk("scr_mem8", fromm2, 32'h12345678);
    do_req(1'b1, 32'h04, 32'hcafef00d, 0, lat, bc);
    do_req(1'b0, 32'h04, 0, 0, lat, bc);
    chk("rd04_data", fromm2, 32'hcafef00d);
    for (int i = 0; i < 40 && busy2; i++) @(negedge clock);
    req2 = 1'b1; we = 1'b1; adr = 32'h04; tom = 32'h11111111;
    @(negedge clock);
    req2 = 1'b0;
    chk("mid_busy", {31'b0, busy2}, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("mid_ready", {31'b0, ready2}, 0);
    chk("mid_busy0", {31'b0, busy2}, 0);
    chk("mid_fromm", fromm2, 0);
    do_req(1'b0, 32'h04, 0, 0, lat, bc);
    chk("mid_rd04", fromm2, 0);
    do_req(1'b0, 32'h08, 0, 0, lat, bc);
    chk("mid_rd08", fromm2, 0);
    @(negedge clock);
    f0 = -1; s0 = -1; f15 = -1; s15 = -1;
    we = 1'b0; adr = 32'h10; req0 = 1'b1; req15 = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clock);
      if (ready0) begin
        if (f0 < 0) f0 = i; else if (s0 < 0) s0 = i;
      end
      if (ready15) begin
        if (f15 < 0) f15 = i; else if (s15 < 0) s15 = i;
      end
    end
    req0 = 1'b0; req15 = 1'b0;
    chk("w0_lat", f0, 1);
    chk("w0_space", s0 - f0, 2);
    chk("w15_lat", f15, 16);
    chk("w15_space", s15 - f15, 17);
    chk("w0_err", {31'b0, err0}, 0);
    chk("w15_fromm", fromm15, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
